// File: rtl/imm_encode.sv
// Immediate encoder: scatters a 32-bit immediate into the instr[31:7] layout for a given
// imm_src type, flags unrepresentable values, through a two-stage valid/ready pipeline.
module imm_encode #(
    parameter int DATA_WIDTH   = 32,
    parameter int IMMSRC_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IMMSRC_WIDTH-1:0] imm_src,
    input  logic [DATA_WIDTH-1:0]   imm_value,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [24:0]             instr_imm,
    output logic [24:0]             imm_mask,
    output logic                    range_err,
    output logic [15:0]             err_count
);

    typedef enum logic [2:0] {
        SRC_I     = 3'd0,
        SRC_S     = 3'd1,
        SRC_B     = 3'd2,
        SRC_U     = 3'd3,
        SRC_J     = 3'd4,
        SRC_SHAMT = 3'd5,
        SRC_IU    = 3'd6,
        SRC_BAD   = 3'd7
    } imm_src_e;

    logic                    s1_valid_q, s1_valid_d;
    logic [IMMSRC_WIDTH-1:0] s1_src_q,   s1_src_d;
    logic [DATA_WIDTH-1:0]   s1_val_q,   s1_val_d;
    logic                    s2_valid_q, s2_valid_d;
    logic [24:0]             s2_imm_q,   s2_imm_d;
    logic [24:0]             s2_mask_q,  s2_mask_d;
    logic                    s2_err_q,   s2_err_d;
    logic [15:0]             err_cnt_q,  err_cnt_d;

    logic                    s1_load, s2_load;
    logic [24:0]             enc_imm, enc_mask;
    logic                    enc_err;
    logic [DATA_WIDTH-1:0]   v;

    assign s2_load  = !s2_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = s1_load;

    // Encoder: the error terms check that the bits the field drops are pure sign/zero extension.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        enc_imm  = '0;
        enc_mask = '0;
        enc_err  = 1'b0;
        v        = s1_val_q;
        case (imm_src_e'(s1_src_q[2:0]))
            SRC_I, SRC_IU: begin
                enc_imm[24:13] = v[11:0];
                enc_mask       = 25'h1FFE000;
                if (s1_src_q[2:0] == SRC_IU) enc_err = |v[31:12];
                else                         enc_err = (|v[31:11]) && !(&v[31:11]);
            end
            SRC_SHAMT: begin
                enc_imm[17:13] = v[4:0];
                enc_mask       = 25'h003E000;
                enc_err        = (|v[31:4]) && !(&v[31:4]);
            end
            SRC_S: begin
                enc_imm[24:18] = v[11:5];
                enc_imm[4:0]   = v[4:0];
                enc_mask       = 25'h1FC001F;
                enc_err        = (|v[31:11]) && !(&v[31:11]);
            end
            SRC_B: begin
                enc_imm[24]    = v[12];
                enc_imm[23:18] = v[10:5];
                enc_imm[4:1]   = v[4:1];
                enc_imm[0]     = v[11];
                enc_mask       = 25'h1FC001F;
                enc_err        = ((|v[31:12]) && !(&v[31:12])) || v[0];
            end
            SRC_U: begin
                enc_imm[24:5] = v[31:12];
                enc_mask      = 25'h1FFFFE0;
                enc_err       = |v[11:0];
            end
            SRC_J: begin
                enc_imm[24]    = v[20];
                enc_imm[23:14] = v[10:1];
                enc_imm[13]    = v[11];
                enc_imm[12:5]  = v[19:12];
                enc_mask       = 25'h1FFFFE0;
                enc_err        = ((|v[31:20]) && !(&v[31:20])) || v[0];
            end
            default: enc_err = 1'b1;
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_src_d   = s1_src_q;
        s1_val_d   = s1_val_q;
        s2_valid_d = s2_valid_q;
        s2_imm_d   = s2_imm_q;
        s2_mask_d  = s2_mask_q;
        s2_err_d   = s2_err_q;
        err_cnt_d  = err_cnt_q;

        if (s1_load) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_src_d = imm_src;
                s1_val_d = imm_value;
            end
        end
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_imm_d  = enc_imm;
                s2_mask_d = enc_mask;
                s2_err_d  = enc_err;
            end
        end
        if (s2_valid_q && out_ready && s2_err_q && err_cnt_q != 16'hFFFF)
            err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: data registers are reset too, so outputs read zero while idle after reset.
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_src_q   <= '0;
            s1_val_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_imm_q   <= '0;
            s2_mask_q  <= '0;
            s2_err_q   <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
            s1_valid_q <= s1_valid_d;
            s1_src_q   <= s1_src_d;
            s1_val_q   <= s1_val_d;
            s2_valid_q <= s2_valid_d;
            s2_imm_q   <= s2_imm_d;
            s2_mask_q  <= s2_mask_d;
            s2_err_q   <= s2_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign instr_imm = s2_imm_q;
    assign imm_mask  = s2_mask_q;
    assign range_err = s2_err_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_imm_encode.sv
// Bench for imm_encode: scoreboard of expected encodings (model + decode round-trip for
// range_err) checked on every output handshake, plus directed scenario checks.
module tb_imm_encode;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  imm_src;
    logic [31:0] imm_value;
    logic        out_valid;
    logic        out_ready;
    logic [24:0] instr_imm;
    logic [24:0] imm_mask;
    logic        range_err;
    logic [15:0] err_count;

    typedef struct {
        logic [24:0] imm;
        logic [24:0] mask;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors    = 0;
    int   checks    = 0;
    int   out_count = 0;

    imm_encode #(.DATA_WIDTH(32), .IMMSRC_WIDTH(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm_src   (imm_src),
        .imm_value (imm_value),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr_imm (instr_imm),
        .imm_mask  (imm_mask),
        .range_err (range_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] decode(input logic [2:0] src, input logic [24:0] i);
        case (src)
            3'd0:    return {{20{i[24]}}, i[24:13]};
            3'd6:    return {20'b0, i[24:13]};
            3'd5:    return {{27{i[17]}}, i[17:13]};
            3'd1:    return {{20{i[24]}}, i[24:18], i[4:0]};
            3'd2:    return {{19{i[24]}}, i[24], i[0], i[23:18], i[4:1], 1'b0};
            3'd3:    return {i[24:5], 12'b0};
            3'd4:    return {{11{i[24]}}, i[24], i[12:5], i[13], i[23:14], 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    function automatic exp_t model(input logic [2:0] src, input logic [31:0] v);
        exp_t e;
        e.imm  = '0;
        e.mask = '0;
        case (src)
            3'd0, 3'd6: begin e.imm[24:13] = v[11:0]; e.mask = 25'h1FFE000; end
            3'd5:       begin e.imm[17:13] = v[4:0];  e.mask = 25'h003E000; end
            3'd1: begin
                e.imm[24:18] = v[11:5]; e.imm[4:0] = v[4:0]; e.mask = 25'h1FC001F;
            end
            3'd2: begin
                e.imm[24] = v[12]; e.imm[23:18] = v[10:5]; e.imm[4:1] = v[4:1];
                e.imm[0] = v[11]; e.mask = 25'h1FC001F;
            end
            3'd3: begin e.imm[24:5] = v[31:12]; e.mask = 25'h1FFFFE0; end
            3'd4: begin
                e.imm[24] = v[20]; e.imm[23:14] = v[10:1]; e.imm[13] = v[11];
                e.imm[12:5] = v[19:12]; e.mask = 25'h1FFFFE0;
            end
            default: ;
        endcase
        e.err = (src == 3'd7) || (decode(src, e.imm) != v);
        return e;
    endfunction

    // Monitor: sampled mid-cycle; inputs change only just after the rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                out_count++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got imm=%h mask=%h err=%b, expected no output",
                             instr_imm, imm_mask, range_err);
                end else begin
                    mon_e = sb.pop_front();
                    if ({instr_imm, imm_mask, range_err} !== {mon_e.imm, mon_e.mask, mon_e.err}) begin
                        errors++;
                        $display("FAIL sb_output: got imm=%h mask=%h err=%b, expected imm=%h mask=%h err=%b",
                                 instr_imm, imm_mask, range_err, mon_e.imm, mon_e.mask, mon_e.err);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(model(imm_src, imm_value));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [2:0] src, input logic [31:0] val);
        logic acc;
        acc       = 1'b0;
        in_valid  = 1'b1;
        imm_src   = src;
        imm_value = val;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL push_timeout: got no accept in 50 cycles, expected accept (src=%0d val=%h)", src, val);
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int n = 0; n < 100 && sb.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
        end
    endtask

    task automatic test_reset();
        in_valid  = 1'b0;
        imm_src   = '0;
        imm_value = '0;
        out_ready = 1'b1;
        rst       = 1'b1;
        #1;
        checks++;
        if ({out_valid, in_ready, range_err} !== 3'b010) begin
            errors++;
            $display("FAIL reset_flags: got out_valid=%b in_ready=%b range_err=%b, expected 0 1 0",
                     out_valid, in_ready, range_err);
        end
        checks++;
        if ({instr_imm, imm_mask, err_count} !== 66'd0) begin
            errors++;
            $display("FAIL reset_data: got imm=%h mask=%h err_count=%0d, expected all 0",
                     instr_imm, imm_mask, err_count);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_spec_vectors();
        logic [2:0]  t_src  [10] = '{3'd0, 3'd0, 3'd6, 3'd2, 3'd2, 3'd3, 3'd4, 3'd7, 3'd5, 3'd1};
        logic [31:0] t_val  [10] = '{32'hFFFFF800, 32'h00000800, 32'h00000800, 32'hFFFFFFFE, 32'h00000003,
                                     32'h12345000, 32'h00000800, 32'h12345678, 32'hFFFFFFF0, 32'h00000FFF};
        logic [24:0] t_imm  [10] = '{25'h1000000, 25'h1000000, 25'h1000000, 25'h1FC001F, 25'h0000002,
                                     25'h02468A0, 25'h0002000, 25'h0000000, 25'h0020000, 25'h1FC001F};
        logic [24:0] t_mask [10] = '{25'h1FFE000, 25'h1FFE000, 25'h1FFE000, 25'h1FC001F, 25'h1FC001F,
                                     25'h1FFFFE0, 25'h1FFFFE0, 25'h0000000, 25'h003E000, 25'h1FC001F};
        logic        t_err  [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            push(t_src[k], t_val[k]);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL vec%0d_early: got out_valid=%b one cycle after accept, expected 0", k, out_valid);
            end
            @(posedge clk);
            #1;
            checks++;
            if ({out_valid, instr_imm, imm_mask, range_err} !== {1'b1, t_imm[k], t_mask[k], t_err[k]}) begin
                errors++;
                $display("FAIL vec%0d: got valid=%b imm=%h mask=%h err=%b, expected valid=1 imm=%h mask=%h err=%b",
                         k, out_valid, instr_imm, imm_mask, range_err, t_imm[k], t_mask[k], t_err[k]);
            end
        end
        drain();
        checks++;
        if (err_count !== 16'd4) begin
            errors++;
            $display("FAIL err_count: got %0d, expected 4", err_count);
        end
    endtask

    task automatic test_back_to_back();
        exp_t a;
        int   base;
        a         = model(3'd3, 32'hABCDE000);
        base      = out_count;
        out_ready = 1'b0;
        push(3'd3, 32'hABCDE000);
        push(3'd1, 32'h000007FF);
        in_valid  = 1'b1;
        imm_src   = 3'd4;
        imm_value = 32'h000FF802;
        for (int n = 0; n < 3; n++) begin
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL b2b_stall_ready: got in_ready=%b, expected 0", in_ready);
            end
            checks++;
            if ({out_valid, instr_imm} !== {1'b1, a.imm}) begin
                errors++;
                $display("FAIL b2b_hold: got valid=%b imm=%h, expected valid=1 imm=%h", out_valid, instr_imm, a.imm);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        push(3'd4, 32'h000FF802);
        drain();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_count - base !== 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d outputs, expected 3", out_count - base);
        end
    endtask

    task automatic test_random();
        logic acc;
        in_valid = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc || !in_valid) begin
                in_valid = ($urandom_range(0, 3) != 0);
                imm_src  = 3'($urandom_range(0, 7));
                case ($urandom_range(0, 3))
                    0:       imm_value = $urandom;
                    1:       imm_value = {{20{1'($urandom_range(0, 1))}}, 12'($urandom)};
                    2:       imm_value = $urandom & 32'hFFFFF000;
                    default: imm_value = $urandom & 32'h001FFFFE;
                endcase
            end
            out_ready = ($urandom_range(0, 2) != 0);
        end
        @(negedge clk);
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!acc) begin
            // Retract a still-pending request; it never handshook, so nothing was queued for it.
            @(posedge clk);
            #1;
        end
        drain();
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        push(3'd0, 32'h00000800);
        push(3'd2, 32'h00000100);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, in_ready, range_err, err_count} !== {3'b010, 16'd0}) begin
            errors++;
            $display("FAIL midreset: got out_valid=%b in_ready=%b range_err=%b err_count=%0d, expected 0 1 0 0",
                     out_valid, in_ready, range_err, err_count);
        end
        checks++;
        if ({instr_imm, imm_mask} !== 50'd0) begin
            errors++;
            $display("FAIL midreset_data: got imm=%h mask=%h, expected 0 0", instr_imm, imm_mask);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        out_ready = 1'b1;
        push(3'd3, 32'h00001000);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL postreset_early: got out_valid=%b, expected 0", out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, instr_imm, range_err} !== {1'b1, 25'h0000020, 1'b0}) begin
            errors++;
            $display("FAIL postreset_out: got valid=%b imm=%h err=%b, expected valid=1 imm=0000020 err=0",
                     out_valid, instr_imm, range_err);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_spec_vectors();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
